// File: rtl/sa_cache_data.sv
// sa_cache_data: set-associative cache data array with byte-enabled writes, beat-serial refill and post-reset clear sweep.
// Define CACHE_DATA_PARITY_EN to store one even-parity bit per word and flag mismatches on rd_perr.
module sa_cache_data #(
    parameter int SETS   = 8,
    parameter int WAYS   = 2,
    parameter int LINE_W = 64,
    parameter int WORD_W = 16,
    parameter int BEAT_W = 16,
    localparam int IW  = $clog2(SETS),
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int WDS = LINE_W / WORD_W,
    localparam int WDW = (WDS > 1) ? $clog2(WDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [IW-1:0]       req_index,
    input  logic [WW-1:0]       req_way,
    input  logic [WDW-1:0]      req_word,
    input  logic [WORD_W-1:0]   req_wdata,
    input  logic [WORD_W/8-1:0] req_be,
    output logic                rd_valid,
    output logic [LINE_W-1:0]   rd_line,
    output logic                rd_perr,
    input  logic                fill_start,
    input  logic [IW-1:0]       fill_index,
    input  logic [WW-1:0]       fill_way,
    input  logic                fill_beat_valid,
    input  logic [BEAT_W-1:0]   fill_beat_data,
    output logic                fill_busy,
    output logic                fill_done
);
    localparam int AW  = $clog2(SETS * WAYS);
    localparam int NB  = LINE_W / BEAT_W;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_FILL} state_t;

    state_t              r_state, w_state_nxt;
    logic [LINE_W-1:0]   r_mem [SETS*WAYS];
    logic [AW-1:0]       r_clr, r_faddr, w_req_addr, w_fill_addr, w_waddr;
    logic [BCW-1:0]      r_cnt;
    logic [LINE_W-1:0]   r_shadow, r_rd_line, w_fill_line, w_bmask, w_wmask, w_wline, w_merged;
    logic                r_rd_valid, r_done, w_rd_hs, w_beat, w_last, w_we;

    assign w_req_addr  = AW'(int'(req_index) * WAYS + (int'(req_way) & (WAYS - 1)));
    assign w_fill_addr = AW'(int'(fill_index) * WAYS + (int'(fill_way) & (WAYS - 1)));
    assign req_ready   = r_state == S_IDLE;
    assign fill_busy   = r_state == S_FILL;
    assign fill_done   = r_done;
    assign rd_valid    = r_rd_valid;
    assign rd_line     = r_rd_line;
    assign w_rd_hs     = req_ready && req_valid && !req_we;
    assign w_beat      = fill_busy && fill_beat_valid;
    assign w_last      = w_beat && r_cnt == BCW'(NB - 1);
    assign w_we        = r_state == S_CLEAR || (req_ready && req_valid && req_we) || w_last;
    assign w_waddr     = (r_state == S_CLEAR) ? r_clr : fill_busy ? r_faddr : w_req_addr;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: w_state_nxt = (r_clr == AW'(SETS * WAYS - 1)) ? S_IDLE : S_CLEAR;
            S_IDLE:  w_state_nxt = fill_start ? S_FILL : S_IDLE;
            default: w_state_nxt = w_last ? S_IDLE : S_FILL;
        endcase
    end

    // One shared write port: clear, CPU byte write and fill commit are mutually exclusive by state.
    always_comb begin
        w_fill_line = r_shadow;
        w_fill_line[int'(r_cnt) * BEAT_W +: BEAT_W] = fill_beat_data;
        w_bmask = '0;
        for (int b = 0; b < WORD_W / 8; b++)
            w_bmask[int'(req_word) * WORD_W + b * 8 +: 8] = {8{req_be[b]}};
        w_wmask  = req_ready ? w_bmask : '1;
        w_wline  = (r_state == S_CLEAR) ? '0 : fill_busy ? w_fill_line : {WDS{req_wdata}};
        w_merged = (r_mem[w_waddr] & ~w_wmask) | (w_wline & w_wmask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_clr      <= '0;
            r_cnt      <= '0;
            r_faddr    <= '0;
            r_shadow   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_line  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr      <= (r_state == S_CLEAR) ? r_clr + 1'b1 : '0;
            r_rd_valid <= w_rd_hs;
            r_done     <= w_last;
            if (w_rd_hs)
                r_rd_line <= r_mem[w_req_addr];
            if (req_ready && fill_start) begin
                r_faddr <= w_fill_addr;
                r_cnt   <= '0;
            end else if (w_beat) begin
                r_cnt    <= r_cnt + 1'b1;
                r_shadow <= w_fill_line;
            end
        end
    end

    always_ff @(posedge clk)
        if (!rst && w_we)
            r_mem[w_waddr] <= w_merged;

`ifdef CACHE_DATA_PARITY_EN
    logic [WDS-1:0] r_par [SETS*WAYS];
    logic [WDS-1:0] w_par_nxt;
    logic           w_rd_perr, r_rd_perr;

    // Only words touched by the write mask get fresh parity.
    always_comb begin
        w_par_nxt = r_par[w_waddr];
        w_rd_perr = 1'b0;
        for (int i = 0; i < WDS; i++) begin
            if (|w_wmask[i * WORD_W +: WORD_W])
                w_par_nxt[i] = ^w_merged[i * WORD_W +: WORD_W];
            w_rd_perr = w_rd_perr | ((^r_mem[w_req_addr][i * WORD_W +: WORD_W]) != r_par[w_req_addr][i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_we)
            r_par[w_waddr] <= w_par_nxt;
        if (rst)
            r_rd_perr <= 1'b0;
        else if (w_rd_hs)
            r_rd_perr <= w_rd_perr;
    end

    assign rd_perr = r_rd_perr && r_rd_valid;
`else
    assign rd_perr = 1'b0;
`endif
endmodule
